pin_verify_lockout: RTL and testbench
=====================================

# pin_verify_lockout

Parametrised PIN verifier with an attempt counter and a timed lockout, clocked from the 500 Hz system clock. It compares a user-entered PIN of `DIGITS` BCD digits against a stored PIN on each `validPin` strobe and drives the lock/unlock `status` to the door/display logic. After `MAX_TRIES` consecutive mismatches it ignores entries for `LOCK_CYCLES` clock cycles. It sits between the keypad entry/PIN-storage logic and the lock status display.

## Interface
Parameters:
- `DIGITS`, default 4: number of PIN digits.
- `DIGIT_W`, default 4: bits per digit.
- `MAX_TRIES`, default 3: consecutive mismatches allowed before lockout; must be ≥1.
- `LOCK_CYCLES`, default 15000: lockout length in clocks (30 s at 500 Hz); must satisfy 1 ≤ `LOCK_CYCLES` < 2^`LOCK_W`.
- `LOCK_W`, default 16: width of the lockout counter.

Ports (T_W = $clog2(`MAX_TRIES`+1)):
- `clk_500Hz`, in, 1: sole clock; all logic on the rising edge.
- `btnR`, in, 1: reset, synchronous, active-high. Already debounced upstream; used directly.
- `storedPin`, in, `DIGITS`*`DIGIT_W`: reference PIN.
- `userPin`, in, `DIGITS`*`DIGIT_W`: entered PIN; sampled only when `validPin`=1.
- `validPin`, in, 1: one-cycle strobe; entry is complete.
- `relock`, in, 1: level; forces unlocked → locked without consuming an attempt.
- `status`, out, 1: 1 = unlocked, 0 = locked.
- `fail`, out, 1: one-cycle pulse per evaluated mismatch.
- `locked`, out, 1: 1 while in lockout.
- `triesLeft`, out, T_W: remaining attempts before lockout.
- `lockRemain`, out, `LOCK_W`: lockout cycles remaining; 0 outside lockout.

## Operation
- FSM states: `IDLE` (locked, accepting entries), `OPEN` (unlocked), `LOCKOUT`.
- Reset (`btnR`=1) has priority over everything. It forces `IDLE`, `status`=0, `fail`=0, `locked`=0, `triesLeft`=`MAX_TRIES`, `lockRemain`=0.
- Match means a full-width equality of `userPin` and `storedPin`. All `DIGITS`*`DIGIT_W` bits are compared.
- `IDLE` with `validPin`:
  - Match: go to `OPEN`, set `triesLeft`=`MAX_TRIES`.
  - Mismatch: pulse `fail` and decrement `triesLeft`. If `triesLeft` was 1, go to `LOCKOUT`, load `lockRemain`=`LOCK_CYCLES`, and set `locked`=1. `triesLeft` reads 0 during lockout.
- `OPEN`:
  - `relock`=1: go to `IDLE`. `triesLeft` is unchanged and `validPin` is ignored in that cycle (relock wins).
  - `validPin` with match: stay in `OPEN`.
  - `validPin` with mismatch: go to `IDLE` (`status`=0), pulse `fail`, and decrement `triesLeft` by the same rules as `IDLE`, including entry to lockout.
- `LOCKOUT`:
  - `validPin` is ignored: no `fail`, no counter change.
  - `relock` has no effect.
  - `lockRemain` decrements every cycle. The cycle it would reach 0, go to `IDLE` with `lockRemain`=0, `locked`=0, and `triesLeft`=`MAX_TRIES`.
- `storedPin` changes take effect at the next `validPin`; no state is cleared when `storedPin` changes.

## Timing
- All outputs are registered. A `validPin` at edge N is reflected in `status`, `fail`, `triesLeft` and `locked` after edge N.
- `fail` is high for exactly one cycle per mismatch. Back-to-back `validPin` strobes are each evaluated.
- Lockout lasts exactly `LOCK_CYCLES` cycles. `locked` is high for `LOCK_CYCLES` cycles, then a `validPin` in the next cycle is evaluated.
- Reset asserted mid-lockout or while `OPEN` takes effect at the next edge and aborts the lockout.

## Configuration
- `PIN_LOCKOUT_EN` defined: full behaviour as above.
- `PIN_LOCKOUT_EN` undefined:
  - No `LOCKOUT` state; mismatches still pulse `fail` and force `IDLE`.
  - `triesLeft` is held at `MAX_TRIES`.
  - `locked` and `lockRemain` are tied to 0.
  - `LOCK_CYCLES` and `LOCK_W` are unused, except that `LOCK_W` still sets the width of `lockRemain`.

## Test plan
Bench uses `DIGITS`=4, `MAX_TRIES`=3, `LOCK_CYCLES`=8, `storedPin`=16'h1234.
- Reset, then `validPin` with `userPin`=16'h1234 → `status`=1 one cycle later; `triesLeft`=3; `fail` never high.
- Two mismatches (16'h0000), then a match → `fail` pulses twice; `triesLeft` goes 2, then 1, then 3; `status`=1.
- Three mismatches → `locked`=1 and `lockRemain`=8 after the third. A correct PIN during lockout gives no `status` change and no `fail`. After 8 cycles, `locked`=0 and `triesLeft`=3, and a correct PIN unlocks.
- While `OPEN`: `relock` pulse → `status`=0 with `triesLeft` still 3. Separately, a mismatch while `OPEN` → `status`=0, `fail` pulse, `triesLeft`=2.
- `relock` and a mismatching `validPin` in the same cycle while `OPEN` → `status`=0, no `fail`, `triesLeft`=3. Assert `btnR` mid-lockout → all outputs at reset values next cycle.
- Build with `PIN_LOCKOUT_EN` undefined: five mismatches → five `fail` pulses, `locked`=0, `triesLeft`=3; a correct PIN then unlocks.

Source files
------------

// File: rtl/pin_verify_lockout.sv
// pin_verify_lockout: PIN compare with attempt counting and timed lockout (lockout enabled by PIN_LOCKOUT_EN)
module pin_verify_lockout #(
   parameter int DIGITS      = 4,
   parameter int DIGIT_W     = 4,
   parameter int MAX_TRIES   = 3,
   parameter int LOCK_CYCLES = 15000,
   parameter int LOCK_W      = 16
) (
   input  logic                              clk_500Hz,
   input  logic                              btnR,
   input  logic [DIGITS*DIGIT_W-1:0]         storedPin,
   input  logic [DIGITS*DIGIT_W-1:0]         userPin,
   input  logic                              validPin,
   input  logic                              relock,
   output logic                              status,
   output logic                              fail,
   output logic                              locked,
   output logic [$clog2(MAX_TRIES+1)-1:0]    triesLeft,
   output logic [LOCK_W-1:0]                 lockRemain
);
   localparam int T_W = $clog2(MAX_TRIES + 1);
   localparam logic [T_W-1:0] TRIES_MAX = T_W'(MAX_TRIES);

   typedef enum logic [1:0] {IDLE, OPEN, LOCKOUT} state_t;

   state_t state;
   logic   match;

   assign match = (userPin == storedPin);

`ifndef PIN_LOCKOUT_EN
   logic unused_cfg;
   assign unused_cfg = (LOCK_CYCLES != 0);
   assign locked     = 1'b0;
   assign lockRemain = '0;
   assign triesLeft  = TRIES_MAX;
`endif

   // Evaluate PIN entries, track consecutive misses and run the lockout timer
   always_ff @(posedge clk_500Hz) begin
      if (btnR) begin
         state  <= IDLE;
         status <= 1'b0;
         fail   <= 1'b0;
`ifdef PIN_LOCKOUT_EN
         locked     <= 1'b0;
         triesLeft  <= TRIES_MAX;
         lockRemain <= '0;
`endif
      end else begin
         fail <= 1'b0;
         case (state)
            IDLE, OPEN: begin
               if (state == OPEN && relock) begin
                  state  <= IDLE;
                  status <= 1'b0;
               end else if (validPin && match) begin
                  state  <= OPEN;
                  status <= 1'b1;
`ifdef PIN_LOCKOUT_EN
                  triesLeft <= TRIES_MAX;
`endif
               end else if (validPin) begin
                  state  <= IDLE;
                  status <= 1'b0;
                  fail   <= 1'b1;
`ifdef PIN_LOCKOUT_EN
                  triesLeft <= triesLeft - 1'b1;
                  if (triesLeft == T_W'(1)) begin
                     state      <= LOCKOUT;
                     locked     <= 1'b1;
                     lockRemain <= LOCK_W'(LOCK_CYCLES);
                  end
`endif
               end
            end
`ifdef PIN_LOCKOUT_EN
            LOCKOUT: begin
               lockRemain <= lockRemain - 1'b1;
               if (lockRemain == LOCK_W'(1)) begin
                  state     <= IDLE;
                  locked    <= 1'b0;
                  triesLeft <= TRIES_MAX;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pin_verify_lockout.sv
// tb_pin_verify_lockout: directed and random checks of pin_verify_lockout against an attempt/timer model
module tb_pin_verify_lockout;
   localparam int MAX  = 3;
   localparam int LOCK = 8;

   logic        clk_500Hz = 1'b0;
   logic        btnR      = 1'b0;
   logic [15:0] storedPin = 16'h1234;
   logic [15:0] userPin   = 16'h0000;
   logic        validPin  = 1'b0;
   logic        relock    = 1'b0;
   logic        status, fail, locked;
   logic [1:0]  triesLeft;
   logic [15:0] lockRemain;

   int n_checks = 0;
   int n_fail   = 0;

   bit m_open = 0;
   bit m_fail = 0;
   int m_tries = MAX;
   int m_lock  = 0;

   pin_verify_lockout #(
      .DIGITS(4), .DIGIT_W(4), .MAX_TRIES(MAX), .LOCK_CYCLES(LOCK), .LOCK_W(16)
   ) dut (
      .clk_500Hz(clk_500Hz), .btnR(btnR), .storedPin(storedPin), .userPin(userPin),
      .validPin(validPin), .relock(relock), .status(status), .fail(fail),
      .locked(locked), .triesLeft(triesLeft), .lockRemain(lockRemain)
   );

   always #5 clk_500Hz = ~clk_500Hz;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: an open flag, a remaining-attempts count and a lockout countdown
   task automatic model(input bit r, input bit v, input logic [15:0] p, input bit rl);
      if (r) begin
         m_open = 0; m_fail = 0; m_tries = MAX; m_lock = 0;
      end else begin
         m_fail = 0;
         if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_tries = MAX;
         end else if (m_open && rl) begin
            m_open = 0;
         end else if (v && p == storedPin) begin
            m_open = 1;
            m_tries = MAX;
         end else if (v) begin
            m_fail = 1;
            m_open = 0;
`ifdef PIN_LOCKOUT_EN
            m_tries--;
            if (m_tries == 0) m_lock = LOCK;
`endif
         end
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [15:0] p, input bit rl);
      btnR = r; validPin = v; userPin = p; relock = rl;
      @(posedge clk_500Hz);
      model(r, v, p, rl);
      #1;
      chk("status", 32'(status), 32'(m_open));
      chk("fail", 32'(fail), 32'(m_fail));
      chk("locked", 32'(locked), 32'(m_lock > 0));
      chk("triesLeft", 32'(triesLeft), 32'(m_tries));
      chk("lockRemain", 32'(lockRemain), 32'(m_lock));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 16'h0000, 0);
   endtask

   initial begin
      @(posedge clk_500Hz);
      #1;
      step(1, 0, 16'h0000, 0);
      chk("rst_tries_const", 32'(triesLeft), 32'd3);
      step(0, 1, 16'h1234, 0);
      chk("unlock_const", 32'(status), 32'd1);
      idle(2);
      step(0, 0, 16'h0000, 1);
      step(0, 1, 16'h0000, 0);
      step(0, 1, 16'h0000, 0);
      step(0, 1, 16'h1234, 0);
      step(0, 0, 16'h0000, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 16'h0000, 0);
`ifdef PIN_LOCKOUT_EN
      chk("lock_load_const", 32'(lockRemain), 32'd8);
`endif
      for (int i = 0; i < LOCK; i++) step(0, 1, 16'h1234, 0);
      step(0, 1, 16'h1234, 0);
      step(0, 1, 16'h4321, 0);
      step(0, 1, 16'h1234, 0);
      step(0, 1, 16'h0000, 1);
      step(0, 1, 16'h1234, 0);
      step(0, 1, 16'h1235, 0);
      step(0, 1, 16'h0000, 0);
      step(0, 1, 16'h0000, 0);
      idle(3);
      step(1, 0, 16'h0000, 0);
      chk("rst_abort_const", 32'(lockRemain), 32'd0);
      for (int i = 0; i < 5; i++) step(0, 1, 16'h0000, 0);
      idle(LOCK);
      step(0, 1, 16'h1234, 0);
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 39) == 0) storedPin = 16'($urandom);
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 0 ? storedPin : 16'($urandom),
              $urandom_range(0, 7) == 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
